// File: rtl/dot_product_sequencer.sv
// Buffers operand pairs and streams them into an external MAC one vector at a time,
// then captures the MAC result and the vector's pair count for a ready/valid consumer.
module dot_product_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [15:0] mac_in1,
  output logic [15:0] mac_in2,
  output logic        mac_en,
  output logic        mac_clr,
  input  logic [15:0] mac_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [7:0]  res_count
);

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 8;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned LW   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, HOLD} state_t;

  pair_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] fill_q;
  logic            full, empty, push, pop;
  pair_t           head;

  state_t          state_q, state_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            res_valid_q, res_valid_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic [CW-1:0]   res_count_q, res_count_d;

  assign full     = (fill_q == CNTW'(DEPTH));
  assign empty    = (fill_q == '0);
  assign in_ready = rst & ~full;
  assign push     = in_valid & in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign mac_in1  = head.a;
  assign mac_in2  = head.b;

  // Storage array carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{last: in_last, a: in_a, b: in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + CNTW'(1);
        2'b01:   fill_q <= fill_q - CNTW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      lat_q       <= lat_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    lat_d       = lat_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = CLEAR;
      end
      CLEAR: begin
        mac_clr = 1'b1;
        pcnt_d  = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (!empty) begin
          mac_en = 1'b1;
          pop    = 1'b1;
          if (pcnt_q != {CW{1'b1}}) pcnt_d = pcnt_q + CW'(1);
          if (head.last) begin
            lat_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      // Final accumulation lands MAC_LAT cycles after the last mac_en.
      DRAIN: begin
        if (lat_q == LW'(MAC_LAT - 1)) begin
          res_data_d  = mac_result;
          res_count_d = pcnt_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_count = res_count_q;

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 Parameter: DEPTH, 8, operand FIFO entries (power of 2, >=2).
REQ-002 Parameter: MAC_LAT, 1, cycles from final mac_en to valid mac_result.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  pair accepted when in_valid & in_ready.
REQ-007 in_a  input  16  operand A, signed Q6.9.
REQ-008 in_b  input  16  operand B, signed Q6.9.
REQ-009 in_last  input  1  pair is final element of current vector.
REQ-010 mac_in1  output  16  operand A to MAC.
REQ-011 mac_in2  output  16  operand B to MAC.
REQ-012 mac_en  output  1  MAC accumulates mac_in1*mac_in2 this cycle.
REQ-013 mac_clr  output  1  MAC zeroes its accumulator this cycle.
REQ-014 mac_result  input  16  MAC accumulator, signed Q6.9, saturated.
REQ-015 res_valid  output  1  dot-product result available.
REQ-016 res_ready  input  1  consumer accepts result.
REQ-017 res_data  output  16  captured dot product, Q6.9.
REQ-018 res_count  output  8  pairs in the vector, saturating at 255.

Function
REQ-019 FIFO stores {in_last, in_a, in_b}; in_ready = !full; pointers wrap modulo DEPTH; push and pop in the same cycle leave occupancy unchanged.
REQ-020 FIFO accepts pushes in every FSM state; a pair offered when full is not stored and must be held by the source.
REQ-021 FSM states IDLE, CLEAR, STREAM, DRAIN, HOLD; only CLEAR asserts mac_clr, only STREAM asserts mac_en.
REQ-022 IDLE: FIFO non-empty -> CLEAR next cycle; otherwise stay.
REQ-023 CLEAR: mac_clr=1 for exactly one cycle, pair counter zeroed, -> STREAM.
REQ-024 STREAM: mac_en = !empty; mac_in1/mac_in2 = FIFO head (combinational); pop occurs whenever mac_en=1; pair counter increments per pop, saturating at 255.
REQ-025 STREAM with FIFO empty: mac_en=0 bubble, state held; mac_in1/mac_in2 are don't-care when mac_en=0.
REQ-026 Popped entry with last=1 -> DRAIN; no further pops until the next CLEAR, even if FIFO is non-empty.
REQ-027 DRAIN: wait MAC_LAT cycles, then register mac_result into res_data and counter into res_count, set res_valid, -> HOLD.
REQ-028 HOLD: res_valid, res_data, res_count stable until res_valid & res_ready; handshake cycle -> IDLE, res_valid=0 next cycle.
REQ-029 Every vector has at least one pair; minimum per-vector overhead is CLEAR + MAC_LAT + HOLD + IDLE cycles.
REQ-030 Pairs reach mac_in1/mac_in2 in acceptance order, never dropped or duplicated.

Reset
REQ-031 rst low at a clock edge: state IDLE, FIFO empty, counter 0, mac_en=0, mac_clr=0, res_valid=0, res_data=0, res_count=0.
REQ-032 in_ready=0 while rst is low; in_ready=1 on the first cycle after rst returns high.
REQ-033 Reset mid-vector discards buffered pairs and any pending result; the next vector begins with CLEAR.

Verification
REQ-034 Push 3 pairs (0x0200, 0x0400), last on third, res_ready=1 -> mac_clr one cycle, then mac_en 3 consecutive cycles, res_data=0x0C00, res_count=3.
REQ-035 Hold res_ready=0 in HOLD, offer DEPTH+1 pairs -> in_ready=0 after DEPTH pushes, extra pair held; release res_ready -> all pairs streamed in order.
REQ-036 Single 20-pair vector with continuous push/pop across pointer wrap -> mac_in sequence equals input order, res_count=20.
REQ-037 Toggle in_valid every other cycle in a 4-pair vector -> mac_en bubbles, state stays STREAM, result equals MAC model.
REQ-038 rst low one cycle after 2 of 4 pairs -> res_valid=0, FIFO empty; following 1-pair vector yields res_count=1.
